enemy_driver: RTL and testbench

ENEMY_DRIVER -- requirements
Module: enemy_driver

---
 rtl/enemy_driver.sv | 178 +++++++++++++++++
 tb/tb_enemy_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_driver.sv
// enemy_driver: timing, randomness and combat glue around an external enemy FSM.
//
// Ports
//   clock        in   single system clock, rising edge
//   reset        in   synchronous, active-high reset
//   x_pos[1:0]   in   enemy lane from the enemy FSM (0 none, 1 left, 2 middle, 3 right)
//   speed        in   move-rate select (0 slow, 1 fast)
//   attack       in   attack-rate select (0 punch every 4 moves, 1 every 2)
//   dead         in   enemy FSM dead flag
//   player_lane  in   player lane, same encoding as x_pos
//   punch        in   one-cycle player punch request
//   health[3:0]  out  registered enemy health
//   go           out  registered pseudo-random direction bit (LFSR bit 0)
//   enemy_tick   out  one-cycle enable that advances the enemy FSM
//   enemy_punch  out  one-cycle pulse, enemy throws a punch
//   hit          out  one-cycle pulse, player punch accepted
module enemy_driver #(
    parameter int unsigned SLOW_DIV   = 50000000,
    parameter int unsigned FAST_DIV   = 25000000,
    parameter int unsigned COOLDOWN   = 12500000,
    parameter logic [3:0]  MAX_HEALTH = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] x_pos,
    input  logic       speed,
    input  logic       attack,
    input  logic       dead,
    input  logic [1:0] player_lane,
    input  logic       punch,
    output logic [3:0] health,
    output logic       go,
    output logic       enemy_tick,
    output logic       enemy_punch,
    output logic       hit
);

    // Terminal counts; a divide of 0 or 1 degenerates to a tick every cycle.
    localparam int unsigned SLOW_LAST = (SLOW_DIV > 1) ? SLOW_DIV - 1 : 0;
    localparam int unsigned FAST_LAST = (FAST_DIV > 1) ? FAST_DIV - 1 : 0;
    localparam int unsigned MAX_LAST  = (SLOW_LAST > FAST_LAST) ? SLOW_LAST : FAST_LAST;
    localparam int unsigned DIV_W     = $clog2(MAX_LAST + 2);
    // A cooldown of 0 still blocks for one cycle.
    localparam int unsigned COOL_EFF  = (COOLDOWN < 1) ? 1 : COOLDOWN;
    localparam int unsigned COOL_LAST = COOL_EFF - 1;
    localparam int unsigned COOL_W    = $clog2(COOL_LAST + 2);

    typedef enum logic [1:0] {
        FIGHT = 2'd0,
        COOL  = 2'd1,
        KO    = 2'd2
    } state_t;

    // ---------------- move-tick divider and LFSR ----------------
    logic [DIV_W-1:0] div_cnt_reg;
    logic [DIV_W-1:0] div_last;
    logic             tick_next;
    logic             tick_reg;
    logic [7:0]       lfsr_reg;
    logic             lfsr_fb;

    assign div_last = speed ? DIV_W'(FAST_LAST) : DIV_W'(SLOW_LAST);
    // ">=" rather than "==" so a slow-to-fast switch past the new limit
    // ticks immediately instead of wrapping around the counter.
    assign tick_next = (div_cnt_reg >= div_last);
    // Taps 8,6,5,4 (1-based) of a left-shifting register.
    assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
            lfsr_reg    <= 8'hA5;
        end else begin
            tick_reg    <= tick_next;
            div_cnt_reg <= tick_next ? '0 : div_cnt_reg + DIV_W'(1);
            // Advancing on the edge that raises enemy_tick makes the new go
            // bit visible in the same cycle as the tick.
            if (tick_next) begin
                lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};
            end
        end
    end

    assign enemy_tick = tick_reg;
    assign go         = lfsr_reg[0];

    // ---------------- move counting / enemy punches ----------------
    logic [1:0] prev_x_reg;
    logic [2:0] move_cnt_reg, move_cnt_next;
    logic [2:0] move_inc, move_thresh;
    logic       enemy_punch_reg, enemy_punch_next;
    logic       alive, moved;

    logic [3:0]        health_reg, health_next;
    logic              hit_reg, hit_next;
    state_t            state_reg, state_next;
    logic [COOL_W-1:0] cool_cnt_reg, cool_cnt_next;
    logic              accept;

    assign alive       = !dead && (health_reg != 4'd0);
    assign moved       = (x_pos != prev_x_reg) && (x_pos != 2'd0);
    assign move_inc    = move_cnt_reg + 3'd1;
    assign move_thresh = attack ? 3'd2 : 3'd4;

    always_comb begin
        move_cnt_next    = move_cnt_reg;
        enemy_punch_next = 1'b0;
        if (alive && moved) begin
            // ">=" covers attack rising while the count already sits at 2 or 3.
            if (move_inc >= move_thresh) begin
                enemy_punch_next = 1'b1;
                move_cnt_next    = 3'd0;
            end else begin
                move_cnt_next = move_inc;
            end
        end
    end

    // ---------------- combat FSM ----------------
    assign accept = punch && (player_lane == x_pos) && (x_pos != 2'd0) && !dead;

    always_comb begin
        state_next    = state_reg;
        health_next   = health_reg;
        hit_next      = 1'b0;
        cool_cnt_next = cool_cnt_reg;
        case (state_reg)
            FIGHT: begin
                if (accept && health_reg != 4'd0) begin
                    health_next   = health_reg - 4'd1;
                    hit_next      = 1'b1;
                    cool_cnt_next = '0;
                    state_next    = (health_reg == 4'd1) ? KO : COOL;
                end
            end
            COOL: begin
                if (cool_cnt_reg >= COOL_W'(COOL_LAST)) begin
                    cool_cnt_next = '0;
                    state_next    = FIGHT;
                end else begin
                    cool_cnt_next = cool_cnt_reg + COOL_W'(1);
                end
            end
            KO: begin
                health_next = 4'd0;
            end
            default: begin
                state_next = FIGHT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_x_reg      <= 2'd0;
            move_cnt_reg    <= 3'd0;
            enemy_punch_reg <= 1'b0;
            health_reg      <= MAX_HEALTH;
            hit_reg         <= 1'b0;
            state_reg       <= FIGHT;
            cool_cnt_reg    <= '0;
        end else begin
            prev_x_reg      <= x_pos;
            move_cnt_reg    <= move_cnt_next;
            enemy_punch_reg <= enemy_punch_next;
            health_reg      <= health_next;
            hit_reg         <= hit_next;
            state_reg       <= state_next;
            cool_cnt_reg    <= cool_cnt_next;
        end
    end

    assign health      = health_reg;
    assign hit         = hit_reg;
    assign enemy_punch = enemy_punch_reg;

endmodule

// File: tb/tb_enemy_driver.sv
// Scoreboard bench for enemy_driver: a behavioural model queues the pulses it
// expects (tagged with the cycle they must appear in); a monitor on the falling
// edge pops and compares whenever a pulse is expected or the DUT produces one.
module tb_enemy_driver;

    localparam int SLOW = 8;
    localparam int FAST = 4;
    localparam int CD   = 3;
    localparam int MH   = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] x_pos;
    logic       speed;
    logic       attack;
    logic       dead;
    logic [1:0] player_lane;
    logic       punch;
    logic [3:0] health;
    logic       go;
    logic       enemy_tick;
    logic       enemy_punch;
    logic       hit;

    enemy_driver #(
        .SLOW_DIV(SLOW), .FAST_DIV(FAST), .COOLDOWN(CD), .MAX_HEALTH(4'(MH))
    ) dut (
        .clock(clock), .reset(reset), .x_pos(x_pos), .speed(speed),
        .attack(attack), .dead(dead), .player_lane(player_lane), .punch(punch),
        .health(health), .go(go), .enemy_tick(enemy_tick),
        .enemy_punch(enemy_punch), .hit(hit)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } ev_t;
    ev_t tick_q[$];
    ev_t epunch_q[$];
    ev_t hit_q[$];

    // ---------------- reference model (game rules, not circuit) ----------------
    int         m_since;      // cycles elapsed since the last move tick
    logic [7:0] m_lfsr;
    logic [1:0] m_prev;
    int         m_moves;
    int         m_health;
    int         m_cool_left;  // further punches ignored while > 0

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        int taps[4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= l[taps[i]-1];
        return {l[6:0], fb};
    endfunction

    // Predict what the coming clock edge produces from the current inputs.
    task automatic model_step();
        int  tag = cyc + 1;
        int  lim;
        bit  alive;
        if (reset) begin
            m_since = 0; m_lfsr = 8'hA5; m_prev = 2'd0; m_moves = 0;
            m_health = MH; m_cool_left = 0;
            return;
        end
        lim = speed ? FAST : SLOW;
        if (m_since + 1 >= lim) begin
            m_since = 0;
            m_lfsr  = lfsr_step(m_lfsr);
            tick_q.push_back('{tag, {7'd0, m_lfsr[0]}});
        end else begin
            m_since++;
        end
        alive = !dead && (m_health != 0);
        if (alive && x_pos != m_prev && x_pos != 2'd0) begin
            m_moves++;
            if (m_moves >= (attack ? 2 : 4)) begin
                epunch_q.push_back('{tag, 8'd0});
                m_moves = 0;
            end
        end
        m_prev = x_pos;
        if (m_health != 0) begin
            if (m_cool_left > 0) begin
                m_cool_left--;
            end else if (punch && player_lane == x_pos && x_pos != 2'd0 && !dead) begin
                m_health--;
                hit_q.push_back('{tag, 8'(m_health)});
                if (m_health != 0) m_cool_left = CD;
            end
        end
    endtask

    // ---------------- monitor ----------------
    task automatic score(input string name, input bit has_exp, input bit pulse,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (has_exp && pulse && act == exp) passes++;
        else $display("FAIL %s cyc=%0d pulse=%0b data=%0h required pulse=%0b data=%0h",
                      name, cyc, pulse, act, has_exp, exp);
    endtask

    always @(negedge clock) begin
        bit e;
        while (tick_q.size() > 0 && tick_q[0].cyc < cyc) begin
            score("tick_late", 1'b1, 1'b0, 8'd0, 8'd0); void'(tick_q.pop_front());
        end
        while (epunch_q.size() > 0 && epunch_q[0].cyc < cyc) begin
            score("epunch_late", 1'b1, 1'b0, 8'd0, 8'd0); void'(epunch_q.pop_front());
        end
        while (hit_q.size() > 0 && hit_q[0].cyc < cyc) begin
            score("hit_late", 1'b1, 1'b0, 8'd0, 8'd0); void'(hit_q.pop_front());
        end
        e = tick_q.size() > 0 && tick_q[0].cyc == cyc;
        if (e || enemy_tick)
            score("tick_go", e, enemy_tick, {7'd0, go}, e ? tick_q[0].data : 8'd0);
        if (e) void'(tick_q.pop_front());
        e = epunch_q.size() > 0 && epunch_q[0].cyc == cyc;
        if (e || enemy_punch) score("enemy_punch", e, enemy_punch, 8'd0, 8'd0);
        if (e) void'(epunch_q.pop_front());
        e = hit_q.size() > 0 && hit_q[0].cyc == cyc;
        if (e || hit)
            score("hit_health", e, hit, {4'd0, health}, e ? hit_q[0].data : 8'd0);
        if (e) void'(hit_q.pop_front());
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic do_punch(input logic [1:0] lane, input logic [1:0] x);
        player_lane = lane; x_pos = x; punch = 1'b1;
        run(1);
        punch = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; x_pos = 2'd0; speed = 1'b0; attack = 1'b0; dead = 1'b0;
        player_lane = 2'd0; punch = 1'b0;
        run(2);
        reset = 1'b0;
        check("reset_health", int'(health), MH);
        check("reset_go", int'(go), 1);
        check("reset_tick", int'(enemy_tick), 0);
        check("reset_epunch", int'(enemy_punch), 0);
        check("reset_hit", int'(hit), 0);

        // Divider: 32 slow cycles, then switch to fast with the counter at 6.
        run(32);
        run(6);
        speed = 1'b1;
        run(10);
        speed = 1'b0;

        // Moves 1,2,3,1 with attack=0, then 0,1,2,3,1 with attack=1.
        for (int i = 0; i < 4; i++) begin
            x_pos = (i == 3) ? 2'd1 : 2'(i + 1);
            run(10);
        end
        attack = 1'b1;
        x_pos = 2'd0;
        run(10);
        for (int i = 0; i < 4; i++) begin
            x_pos = (i == 3) ? 2'd1 : 2'(i + 1);
            run(10);
        end
        attack = 1'b0;

        // Punch, ignored punch inside cooldown, punch after cooldown.
        x_pos = 2'd2; run(2);
        do_punch(2'd2, 2'd2);
        run(1);
        do_punch(2'd2, 2'd2);
        run(3);
        do_punch(2'd2, 2'd2);
        run(2);
        check("health_after_cool", int'(health), 8);

        // Wrong lane and empty lane: no hit.
        run(4);
        do_punch(2'd1, 2'd3);
        run(4);
        do_punch(2'd0, 2'd0);
        run(4);
        check("health_miss", int'(health), 8);

        // Knock-out sequence.
        do_reset();
        check("health_pre_ko", int'(health), MH);
        for (int i = 0; i < 10; i++) begin
            do_punch(2'd2, 2'd2);
            run(4);
        end
        check("health_ko", int'(health), 0);
        do_punch(2'd2, 2'd2);
        run(2);
        attack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x_pos = (i % 2 == 0) ? 2'd1 : 2'd3;
            run(3);
        end
        run(12);
        check("health_ko_held", int'(health), 0);

        // Reset out of KO, ten ticks of go sequence, then back in the fight.
        attack = 1'b0; speed = 1'b0; x_pos = 2'd2;
        do_reset();
        check("health_after_ko_reset", int'(health), MH);
        check("go_after_ko_reset", int'(go), 1);
        run(80);
        do_punch(2'd2, 2'd2);
        run(4);
        check("health_refight", int'(health), MH - 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) speed = $urandom_range(0, 1);
            if ($urandom_range(0, 29) == 0) attack = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) x_pos = 2'($urandom_range(0, 3));
            player_lane = 2'($urandom_range(0, 3));
            punch = ($urandom_range(0, 3) == 0);
            dead  = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 299) == 0);
            run(1);
        end
        reset = 1'b0; punch = 1'b0; dead = 1'b0;
        run(3);
        check("tick_q_drained", tick_q.size(), 0);
        check("epunch_q_drained", epunch_q.size(), 0);
        check("hit_q_drained", hit_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
